// File: rtl/bitcruncher_pkg.sv
// Shared definitions for the bitcruncher microsequencer: field widths, opcodes,
// control strobe indices, ALU codes, state encoding and the decoded-opcode bundle.
package bitcruncher_pkg;

  localparam int unsigned IR_W    = 16;
  localparam int unsigned OPC_W   = 8;
  localparam int unsigned ADDR_W  = IR_W - OPC_W;
  localparam int unsigned CTRL_W  = 11;
  localparam int unsigned ALUOP_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP    = 8'h00;
  localparam logic [OPC_W-1:0] OP_STORE  = 8'h01;
  localparam logic [OPC_W-1:0] OP_LOAD   = 8'h02;
  localparam logic [OPC_W-1:0] OP_ADD    = 8'h03;
  localparam logic [OPC_W-1:0] OP_SUB    = 8'h04;
  localparam logic [OPC_W-1:0] OP_JMPGEZ = 8'h05;
  localparam logic [OPC_W-1:0] OP_JMP    = 8'h06;
  localparam logic [OPC_W-1:0] OP_HALT   = 8'h07;
  localparam logic [OPC_W-1:0] OP_AND    = 8'h0A;
  localparam logic [OPC_W-1:0] OP_OR     = 8'h0B;
  localparam logic [OPC_W-1:0] OP_NOT    = 8'h0C;
  localparam logic [OPC_W-1:0] OP_SHR    = 8'h0D;
  localparam logic [OPC_W-1:0] OP_SHL    = 8'h0E;
  localparam logic [OPC_W-1:0] OP_CLR    = 8'h0F;

  localparam int unsigned C_PC_INC    = 0;
  localparam int unsigned C_PC_MAR    = 1;
  localparam int unsigned C_MEM_WR    = 2;
  localparam int unsigned C_MEM_RD    = 3;
  localparam int unsigned C_IR_LD     = 4;
  localparam int unsigned C_ADDR_MAR  = 5;
  localparam int unsigned C_ADDR_PC   = 6;
  localparam int unsigned C_MBR_BR    = 7;
  localparam int unsigned C_ACC_MBR   = 8;
  localparam int unsigned C_ALU_ACC   = 9;
  localparam int unsigned C_ACC_CLR   = 10;

  localparam logic [ALUOP_W-1:0] ALU_PASS_B = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_ADD    = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_SUB    = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_AND    = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_OR     = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_NOT    = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SHL    = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SHR    = 4'd7;

  typedef enum logic [3:0] {
    S_RST = 4'd0,
    S_F1  = 4'd1,
    S_F2  = 4'd2,
    S_F3  = 4'd3,
    S_DEC = 4'd4,
    S_ST1 = 4'd5,
    S_ST2 = 4'd6,
    S_RD  = 4'd7,
    S_BRL = 4'd8,
    S_WB  = 4'd9,
    S_HLT = 4'd10
  } state_t;

  typedef struct packed {
    logic               is_mem_rd;
    logic               is_store;
    logic               is_jump;
    logic               is_cond_jump;
    logic               is_alu_only;
    logic               is_clr;
    logic               is_halt;
    logic               illegal;
    logic [ALUOP_W-1:0] alu_op;
  } op_dec_t;

endpackage

// File: rtl/cu_opdecode.sv
// Combinational opcode classifier: instruction class flags plus the ALU code
// the write-back state will present.
module cu_opdecode
  import bitcruncher_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  output op_dec_t          dec
);

  always_comb begin
    dec = '0;
    unique case (opc)
      OP_NOP:    ;
      OP_STORE:  dec.is_store = 1'b1;
      OP_LOAD:   begin dec.is_mem_rd = 1'b1; dec.alu_op = ALU_PASS_B; end
      OP_ADD:    begin dec.is_mem_rd = 1'b1; dec.alu_op = ALU_ADD;    end
      OP_SUB:    begin dec.is_mem_rd = 1'b1; dec.alu_op = ALU_SUB;    end
      OP_AND:    begin dec.is_mem_rd = 1'b1; dec.alu_op = ALU_AND;    end
      OP_OR:     begin dec.is_mem_rd = 1'b1; dec.alu_op = ALU_OR;     end
      OP_JMPGEZ: begin dec.is_jump = 1'b1; dec.is_cond_jump = 1'b1;   end
      OP_JMP:    dec.is_jump = 1'b1;
      OP_HALT:   dec.is_halt = 1'b1;
      OP_NOT:    begin dec.is_alu_only = 1'b1; dec.alu_op = ALU_NOT;  end
      OP_SHR:    begin dec.is_alu_only = 1'b1; dec.alu_op = ALU_SHR;  end
      OP_SHL:    begin dec.is_alu_only = 1'b1; dec.alu_op = ALU_SHL;  end
      OP_CLR:    dec.is_clr = 1'b1;
      default:   dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microsequencer for the bitcruncher datapath: fetch/decode/execute FSM driving
// one-hot control strobes and the ALU op code from state and latched opcode.
module control_unit
  import bitcruncher_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IR_W-1:0]    ir_in,
  input  logic               acc_neg,
  input  logic               mem_ready,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               halted,
  output logic               illegal_op
);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q;
  logic [OPC_W-1:0] dec_opc;
  op_dec_t          dec;
  logic             unused_addr;

  // The address field is routed to MAR/PC by the datapath, not used here.
  assign unused_addr = ^ir_in[ADDR_W-1:0];

  // In DEC the opcode is decoded live from the IR; afterwards from the latched copy.
  assign dec_opc = (state_q == S_DEC) ? ir_in[IR_W-1 -: OPC_W] : opc_q;

  cu_opdecode u_opdecode (
    .opc (dec_opc),
    .dec (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DEC) opc_q <= ir_in[IR_W-1 -: OPC_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl       = '0;
    alu_op     = '0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      S_RST: state_d = S_F1;
      S_F1: begin
        ctrl[C_PC_MAR] = 1'b1;
        state_d        = S_F2;
      end
      S_F2: begin
        ctrl[C_MEM_RD] = 1'b1;
        if (mem_ready) begin
          ctrl[C_PC_INC] = 1'b1;
          state_d        = S_F3;
        end
      end
      S_F3: begin
        ctrl[C_IR_LD] = 1'b1;
        state_d       = S_DEC;
      end
      S_DEC: begin
        state_d = S_F1;
        if (dec.is_store) begin
          ctrl[C_ADDR_MAR] = 1'b1;
          state_d          = S_ST1;
        end else if (dec.is_mem_rd) begin
          ctrl[C_ADDR_MAR] = 1'b1;
          state_d          = S_RD;
        end else if (dec.is_jump) begin
          ctrl[C_ADDR_PC] = !dec.is_cond_jump || !acc_neg;
        end else if (dec.is_alu_only) begin
          state_d = S_WB;
        end else if (dec.is_clr) begin
          ctrl[C_ACC_CLR] = 1'b1;
        end else if (dec.is_halt) begin
          state_d = S_HLT;
        end else begin
          illegal_op = dec.illegal;
        end
      end
      S_ST1: begin
        ctrl[C_ACC_MBR] = 1'b1;
        state_d         = S_ST2;
      end
      S_ST2: begin
        ctrl[C_MEM_WR] = 1'b1;
        if (mem_ready) state_d = S_F1;
      end
      S_RD: begin
        ctrl[C_MEM_RD] = 1'b1;
        if (mem_ready) state_d = S_BRL;
      end
      S_BRL: begin
        ctrl[C_MBR_BR] = 1'b1;
        state_d        = S_WB;
      end
      S_WB: begin
        ctrl[C_ALU_ACC] = 1'b1;
        alu_op          = dec.alu_op;
        state_d         = S_F1;
      end
      S_HLT: halted = 1'b1;
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected strobe traces
// built from the instruction-level rules, replayed cycle by cycle against the DUT.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ir_in;
  logic        acc_neg;
  logic        mem_ready;
  logic [10:0] ctrl;
  logic [3:0]  alu_op;
  logic        halted;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mr;
    logic        an;
    logic [15:0] ir;
    logic [10:0] ctrl;
    logic [3:0]  alu;
    logic        halted;
    logic        ill;
  } step_t;

  step_t q[$];

  control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir_in      (ir_in),
    .acc_neg    (acc_neg),
    .mem_ready  (mem_ready),
    .ctrl       (ctrl),
    .alu_op     (alu_op),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] cb(input int i);
    return 11'(1) << i;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] rw();
    return 16'($urandom);
  endfunction

  task automatic push(input logic mr, input logic an, input logic [15:0] ir,
                      input logic [10:0] c, input logic [3:0] a,
                      input logic h, input logic il);
    step_t s;
    s.mr = mr; s.an = an; s.ir = ir; s.ctrl = c; s.alu = a; s.halted = h; s.ill = il;
    q.push_back(s);
  endtask

  // Expected trace of one instruction; mem_ready is held low for exactly the
  // requested wait count in each memory phase and is random everywhere else.
  task automatic build_instr(input logic [15:0] ir, input int fwait,
                             input int mwait, input int an_force);
    logic [7:0] op;
    logic       an;
    op = ir[15:8];
    an = (an_force < 0) ? rb() : an_force[0];
    push(rb(), rb(), ir, cb(1), 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < fwait; i++) push(1'b0, rb(), ir, cb(3), 4'd0, 1'b0, 1'b0);
    push(1'b1, rb(), ir, cb(3) | cb(0), 4'd0, 1'b0, 1'b0);
    push(rb(), rb(), ir, cb(4), 4'd0, 1'b0, 1'b0);
    case (op)
      8'h01: begin
        push(rb(), an, ir, cb(5), 4'd0, 1'b0, 1'b0);
        push(rb(), rb(), rw(), cb(8), 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < mwait; i++) push(1'b0, rb(), rw(), cb(2), 4'd0, 1'b0, 1'b0);
        push(1'b1, rb(), rw(), cb(2), 4'd0, 1'b0, 1'b0);
      end
      8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B: begin
        logic [3:0] a;
        a = (op == 8'h02) ? 4'd0 : (op == 8'h03) ? 4'd1 : (op == 8'h04) ? 4'd2 :
            (op == 8'h0A) ? 4'd3 : 4'd4;
        push(rb(), an, ir, cb(5), 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < mwait; i++) push(1'b0, rb(), rw(), cb(3), 4'd0, 1'b0, 1'b0);
        push(1'b1, rb(), rw(), cb(3), 4'd0, 1'b0, 1'b0);
        push(rb(), rb(), rw(), cb(7), 4'd0, 1'b0, 1'b0);
        push(rb(), rb(), rw(), cb(9), a, 1'b0, 1'b0);
      end
      8'h05: push(rb(), an, ir, an ? 11'd0 : cb(6), 4'd0, 1'b0, 1'b0);
      8'h06: push(rb(), an, ir, cb(6), 4'd0, 1'b0, 1'b0);
      8'h0C, 8'h0D, 8'h0E: begin
        push(rb(), an, ir, 11'd0, 4'd0, 1'b0, 1'b0);
        push(rb(), rb(), rw(), cb(9), (op == 8'h0C) ? 4'd5 : (op == 8'h0E) ? 4'd6 : 4'd7,
             1'b0, 1'b0);
      end
      8'h0F: push(rb(), an, ir, cb(10), 4'd0, 1'b0, 1'b0);
      8'h00: push(rb(), an, ir, 11'd0, 4'd0, 1'b0, 1'b0);
      8'h07: begin
        push(rb(), an, ir, 11'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 22; i++) push(rb(), rb(), rw(), 11'd0, 4'd0, 1'b1, 1'b0);
      end
      default: push(rb(), an, ir, 11'd0, 4'd0, 1'b0, 1'b1);
    endcase
  endtask

  // Replay up to n queued steps (n<0: all); outputs checked mid-low-phase.
  task automatic run_steps(input string name, input int n);
    step_t s;
    int    k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      s = q.pop_front();
      @(negedge clk);
      mem_ready = s.mr;
      acc_neg   = s.an;
      ir_in     = s.ir;
      #2;
      checks++;
      if ({ctrl, alu_op, halted, illegal_op} !== {s.ctrl, s.alu, s.halted, s.ill}) begin
        errors++;
        $display("FAIL %s step %0d: got ctrl=%h alu=%0d halted=%b ill=%b, want ctrl=%h alu=%0d halted=%b ill=%b",
                 name, k, ctrl, alu_op, halted, illegal_op, s.ctrl, s.alu, s.halted, s.ill);
      end
      k++;
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({ctrl, alu_op, halted, illegal_op} !== 17'd0) begin
      errors++;
      $display("FAIL %s: got ctrl=%h alu=%0d halted=%b ill=%b, want all zero",
               name, ctrl, alu_op, halted, illegal_op);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check_idle(name);
      @(negedge clk);
    end
    rst_n = 1'b1;
    #2;
    check_idle({name, "_rst_state"});
  endtask

  task automatic test_reset();
    do_reset("reset");
    build_instr(16'h0000, 0, 0, -1);
    run_steps("reset_first_fetch", 1);
    run_steps("reset_nop_rest", -1);
  endtask

  task automatic test_load();
    build_instr(16'h0210, 0, 0, -1);
    run_steps("load", -1);
  endtask

  task automatic test_add_wait();
    build_instr(16'h0344, 2, 3, -1);
    run_steps("add_wait", -1);
  endtask

  task automatic test_jmpgez();
    build_instr(16'h0520, 0, 0, 1);
    run_steps("jmpgez_neg", -1);
    build_instr(16'h0520, 1, 0, 0);
    run_steps("jmpgez_pos", -1);
  endtask

  task automatic test_illegal();
    build_instr(16'hFF00, 0, 0, -1);
    run_steps("illegal", -1);
    build_instr(16'h0600, 0, 0, -1);
    run_steps("after_illegal", -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [7:0] op;
      op = 8'($urandom_range(0, 15));
      if (op == 8'h07) op = 8'h00;
      if ($urandom_range(0, 7) == 0) op = 8'($urandom_range(16, 255));
      build_instr({op, 8'($urandom)}, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), -1);
      run_steps("random", -1);
    end
  endtask

  task automatic test_store_reset();
    build_instr(16'h0130, 0, 5, -1);
    run_steps("store_pre_reset", 6);
    q.delete();
    rst_n = 1'b0;
    #1;
    check_idle("store_abort");
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check_idle("store_abort_rst_state");
    build_instr(16'h0130, 0, 0, -1);
    run_steps("store_refetch", -1);
  endtask

  task automatic test_halt();
    build_instr(16'h0700, 0, 0, -1);
    run_steps("halt", -1);
    do_reset("halt_reset");
    build_instr(16'h0E00, 0, 0, -1);
    run_steps("post_halt", -1);
  endtask

  initial begin
    rst_n     = 1'b0;
    ir_in     = '0;
    acc_neg   = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_load();
    test_add_wait();
    test_jmpgez();
    test_illegal();
    test_random();
    test_store_reset();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
